// File: rtl/encoder_16_to_4_seq_if.sv
// Handshake bundle for the sequential 16-to-4 encoder.
// Slave side is the encoder; master side feeds vectors and takes codes.
interface encoder_16_to_4_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] d;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out;
  logic        last;
  logic [4:0]  count;
  logic        zero;

  modport slave (
    input  in_valid, d, out_ready,
    output in_ready, out_valid, out, last, count, zero
  );

  modport master (
    output in_valid, d, out_ready,
    input  in_ready, out_valid, out, last, count, zero
  );
endinterface

// File: rtl/encoder_16_to_4_seq.sv
// Sequential 16-to-4 priority encoder: accepts a request vector and
// streams the index of every set bit, highest first, one per handshake.
module encoder_16_to_4_seq (
  input logic                   clk,
  input logic                   rst,
  input logic                   en,
  encoder_16_to_4_seq_if.slave  bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state;
  logic [15:0] pend;
  logic [4:0]  cnt;
  logic        zero_q;

  logic [3:0]  idx;
  logic [4:0]  pop;
  logic        one_hot;
  logic        accept;
  logic        take;

  always_comb begin
    idx = '0;
    for (int i = 0; i < 16; i++)
      if (pend[i]) idx = 4'(i);
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < 16; i++)
      pop = pop + 5'(bus.d[i]);
  end

  // clearing the lowest set bit leaves zero only for a single-bit pend
  assign one_hot = (pend != 16'd0) &&
                   ((pend & (pend - 16'd1)) == 16'd0);

  assign bus.in_ready  = en & (state == IDLE);
  assign bus.out_valid = en & (state == SCAN);
  assign bus.out       = idx;
  assign bus.last      = one_hot;
  assign bus.count     = cnt;
  assign bus.zero      = zero_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign take   = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pend   <= '0;
      cnt    <= '0;
      zero_q <= 1'b0;
    end else if (en) begin
      zero_q <= accept && (bus.d == 16'd0);
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt <= pop;
            if (bus.d != 16'd0) begin
              pend  <= bus.d;
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (take) begin
            pend <= pend & ~(16'd1 << idx);
            if (one_hot) state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_16_to_4_seq.sv
// Self-checking bench for encoder_16_to_4_seq against a queue-based
// model: each vector expands to its set-bit indices, highest first.
module tb_encoder_16_to_4_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  encoder_16_to_4_seq_if bus ();

  encoder_16_to_4_seq dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: out_ready always 1, 1: toggled 1/0, 2: random en/ready/noise
  task automatic run_vec(input logic [15:0] v, input int mode);
    int q[$];
    int guard;
    int hs_cnt;
    bit hs;
    logic [4:0] exp_cnt;
    exp_cnt = 5'($countones(v));
    for (int i = 15; i >= 0; i--)
      if (v[i]) q.push_back(i);
    en = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready v=%h got=%b exp=1", v, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.d = v;
    tick();
    bus.in_valid = 1'b0;
    bus.d = '0;
    n_checks++;
    if (bus.count !== exp_cnt) begin
      n_fail++;
      $display("FAIL count v=%h got=%0d exp=%0d", v, bus.count, exp_cnt);
    end
    if (v == 16'd0) begin
      n_checks++;
      if ({bus.zero, bus.out_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL zero_vec got zero=%b ov=%b exp zero=1 ov=0",
                 bus.zero, bus.out_valid);
      end
      return;
    end
    guard = 0;
    hs_cnt = 0;
    while (q.size() > 0 && guard < 300) begin
      if (mode == 2) begin
        en = ($urandom_range(0, 3) != 0);
        bus.out_ready = 1'($urandom_range(0, 1));
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.d = 16'($urandom);
      end else if (mode == 1) begin
        en = 1'b1;
        bus.out_ready = (guard % 2 == 0);
      end else begin
        en = 1'b1;
        bus.out_ready = 1'b1;
      end
      #1;
      n_checks++;
      if ({bus.out_valid, bus.out, bus.last, bus.in_ready} !==
          {en, 4'(q[0]), (q.size() == 1), 1'b0}) begin
        n_fail++;
        $display("FAIL scan v=%h got ov=%b out=%0d last=%b ir=%b exp ov=%b out=%0d last=%b ir=0",
                 v, bus.out_valid, bus.out, bus.last, bus.in_ready,
                 en, q[0], (q.size() == 1));
      end
      n_checks++;
      if (bus.count !== exp_cnt) begin
        n_fail++;
        $display("FAIL scan_count got=%0d exp=%0d", bus.count, exp_cnt);
      end
      hs = en && bus.out_ready;
      tick();
      if (hs) begin
        void'(q.pop_front());
        hs_cnt++;
      end
      guard++;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scan_timeout v=%h left=%0d exp=0", v, q.size());
    end
    if (mode == 0) begin
      n_checks++;
      if (guard != $countones(v)) begin
        n_fail++;
        $display("FAIL scan_cycles v=%h got=%0d exp=%0d",
                 v, guard, $countones(v));
      end
    end
    en = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.out, bus.last} !==
        {1'b1, 1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL post_scan got ir=%b ov=%b out=%0d last=%b exp ir=1 ov=0 out=0 last=0",
               bus.in_ready, bus.out_valid, bus.out, bus.last);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    bus.in_valid = 1'b0;
    bus.d = '0;
    bus.out_ready = 1'b0;
    tick();
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.out, bus.last, bus.count, bus.zero} !==
        {1'b1, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset got ir=%b ov=%b out=%0d last=%b cnt=%0d zero=%b",
               bus.in_ready, bus.out_valid, bus.out, bus.last,
               bus.count, bus.zero);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    run_vec(16'h0001, 0);
  endtask

  task automatic test_pattern();
    run_vec(16'h8421, 0);
  endtask

  task automatic test_backpressure();
    run_vec(16'hFFFF, 1);
  endtask

  task automatic test_zero();
    en = 1'b1;
    bus.in_valid = 1'b1;
    bus.d = 16'h0000;
    tick();
    n_checks++;
    if ({bus.zero, bus.count, bus.out_valid, bus.in_ready} !==
        {1'b1, 5'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_first got zero=%b cnt=%0d ov=%b ir=%b exp 1 0 0 1",
               bus.zero, bus.count, bus.out_valid, bus.in_ready);
    end
    tick();
    n_checks++;
    if (bus.zero !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_b2b got=%b exp=1", bus.zero);
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if ({bus.zero, bus.out_valid, bus.in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL zero_clear got zero=%b ov=%b ir=%b exp 0 0 1",
               bus.zero, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_en_gap();
    int seq[3] = '{6, 5, 4};
    en = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.d = 16'h00F0;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.out} !== {1'b1, 4'd7}) begin
      n_fail++;
      $display("FAIL gap_first got ov=%b out=%0d exp 1 7",
               bus.out_valid, bus.out);
    end
    tick();
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({bus.out_valid, bus.in_ready, bus.out, bus.last, bus.count} !==
          {1'b0, 1'b0, 4'd6, 1'b0, 5'd4}) begin
        n_fail++;
        $display("FAIL gap_hold c=%0d got ov=%b ir=%b out=%0d last=%b cnt=%0d",
                 c, bus.out_valid, bus.in_ready, bus.out, bus.last, bus.count);
      end
      tick();
    end
    en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({bus.out_valid, bus.out, bus.last} !==
          {1'b1, 4'(seq[c]), (c == 2)}) begin
        n_fail++;
        $display("FAIL gap_resume c=%0d got ov=%b out=%0d last=%b exp out=%0d",
                 c, bus.out_valid, bus.out, bus.last, seq[c]);
      end
      tick();
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_done got ir=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_scan();
    int seq[2] = '{11, 10};
    en = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.d = 16'h0F00;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if ({bus.out_valid, bus.out} !== {1'b1, 4'(seq[c])}) begin
        n_fail++;
        $display("FAIL rst_pre c=%0d got ov=%b out=%0d exp out=%0d",
                 c, bus.out_valid, bus.out, seq[c]);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.out, bus.last, bus.count, bus.zero} !==
        {1'b1, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid got ir=%b ov=%b out=%0d last=%b cnt=%0d zero=%b",
               bus.in_ready, bus.out_valid, bus.out, bus.last,
               bus.count, bus.zero);
    end
    tick();
    rst = 1'b0;
    tick();
    run_vec(16'h0002, 0);
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int n = 0; n < 40; n++) begin
      v = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      run_vec(v, 2);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.d = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_pattern();
    test_backpressure();
    test_zero();
    test_en_gap();
    test_reset_mid_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
